axi_slave_responder: RTL

AXI_SLAVE_RESPONDER -- requirements
Module: axi_slave_responder

---
 rtl/axi_slave_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_responder.sv
// AXI slave responder: accepts single outstanding write/read bursts, answers with
// constant or address-derived read data, and counts completed transactions.
module axi_slave_responder #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 32,
    parameter int                 ID_W      = 4,
    parameter int                 READY_DLY = 0,
    parameter int                 RD_MODE   = 0,
    parameter logic [DATA_W-1:0]  RD_CONST  = DATA_W'(32'h12345678),
    parameter logic [ADDR_W-1:0]  ERR_BASE  = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
);

    localparam int          BYTES    = DATA_W / 8;
    localparam logic [3:0]  DLY_LAST = (READY_DLY > 0) ? 4'(READY_DLY - 1) : 4'd0;
    localparam int          CPW      = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;
    localparam logic [1:0]  RESP_OK  = 2'b00;
    localparam logic [1:0]  RESP_ERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DLY, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DLY, R_DATA}         r_state_t;

    w_state_t          r_wstate, w_wstate_nxt;
    r_state_t          r_rstate, w_rstate_nxt;
    logic              r_rst_q;
    logic [3:0]        r_wdly, r_rdly;
    logic [8:0]        r_wbeat;
    logic [7:0]        r_rbeat;
    logic [ID_W-1:0]   r_awid, r_arid;
    logic [ADDR_W-1:0] r_awaddr, r_raddr;
    logic [7:0]        r_awlen, r_arlen;
    logic              r_rerr;
    logic [1:0]        r_bresp;
    logic [15:0]       r_wr_cnt, r_rd_cnt;

    logic              w_hold, w_berr;
    logic              w_awready, w_wready, w_bvalid;
    logic              w_arready, w_rvalid, w_rlast;
    logic              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [DATA_W-1:0] w_addr_ext;
    logic              w_unused_wdata;

    // Handshakes stay blocked for the cycle after reset as well as during it.
    assign w_hold  = rst | r_rst_q;
    assign w_aw_hs = s_axi_awvalid & w_awready;
    assign w_w_hs  = s_axi_wvalid & w_wready;
    assign w_b_hs  = w_bvalid & s_axi_bready;
    assign w_ar_hs = s_axi_arvalid & w_arready;
    assign w_r_hs  = w_rvalid & s_axi_rready;
    assign w_berr  = ((r_wbeat + 9'd1) != ({1'b0, r_awlen} + 9'd1)) || (r_awaddr >= ERR_BASE);
    assign w_unused_wdata = ^s_axi_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
        if (rst) begin
            r_wstate <= W_IDLE;
            r_wdly   <= 4'd0;
            r_wbeat  <= 9'd0;
            r_bresp  <= RESP_OK;
            r_wr_cnt <= 16'd0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_wdly   <= (r_wstate == W_DLY) ? r_wdly + 4'd1 : 4'd0;
            if (w_aw_hs)
                r_wbeat <= 9'd0;
            else if (w_w_hs)
                r_wbeat <= r_wbeat + 9'd1;
            if (w_w_hs && s_axi_wlast)
                r_bresp <= w_berr ? RESP_ERR : RESP_OK;
            if (w_b_hs && (r_wr_cnt != 16'hFFFF))
                r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    // NOTE: payload registers are not reset; they are only observed while a
    // valid signal from the reset-cleared FSM qualifies them.
    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_awid   <= s_axi_awid;
            r_awaddr <= s_axi_awaddr;
            r_awlen  <= s_axi_awlen;
        end
        if (w_ar_hs) begin
            r_arid  <= s_axi_arid;
            r_arlen <= s_axi_arlen;
            r_rerr  <= (s_axi_araddr >= ERR_BASE);
            r_raddr <= s_axi_araddr;
        end else if (w_r_hs) begin
            r_raddr <= r_raddr + ADDR_W'(BYTES);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: if (s_axi_awvalid && !w_hold)
                        w_wstate_nxt = (READY_DLY == 0) ? W_DATA : W_DLY;
            W_DLY:  if (r_wdly == DLY_LAST)
                        w_wstate_nxt = s_axi_awvalid ? W_DATA : W_IDLE;
            W_DATA: if (w_w_hs && s_axi_wlast) w_wstate_nxt = W_RESP;
            W_RESP: if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        if (!w_hold) begin
            case (r_wstate)
                W_IDLE:  w_awready = (READY_DLY == 0) && s_axi_awvalid;
                W_DLY:   w_awready = (r_wdly == DLY_LAST);
                W_DATA:  w_wready  = 1'b1;
                W_RESP:  w_bvalid  = 1'b1;
                default: w_awready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rdly   <= 4'd0;
            r_rbeat  <= 8'd0;
            r_rd_cnt <= 16'd0;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rdly   <= (r_rstate == R_DLY) ? r_rdly + 4'd1 : 4'd0;
            if (w_ar_hs)
                r_rbeat <= 8'd0;
            else if (w_r_hs)
                r_rbeat <= r_rbeat + 8'd1;
            if (w_r_hs && w_rlast && (r_rd_cnt != 16'hFFFF))
                r_rd_cnt <= r_rd_cnt + 16'd1;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: if (s_axi_arvalid && !w_hold)
                        w_rstate_nxt = (READY_DLY == 0) ? R_DATA : R_DLY;
            R_DLY:  if (r_rdly == DLY_LAST)
                        w_rstate_nxt = s_axi_arvalid ? R_DATA : R_IDLE;
            R_DATA: if (w_r_hs && w_rlast) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        if (!w_hold) begin
            case (r_rstate)
                R_IDLE:  w_arready = (READY_DLY == 0) && s_axi_arvalid;
                R_DLY:   w_arready = (r_rdly == DLY_LAST);
                R_DATA:  w_rvalid  = 1'b1;
                default: w_arready = 1'b0;
            endcase
        end
        w_rlast = w_rvalid && (r_rbeat == r_arlen);
    end

    always_comb begin
        w_addr_ext          = '0;
        w_addr_ext[CPW-1:0] = r_raddr[CPW-1:0];
    end

    assign s_axi_awready = w_awready;
    assign s_axi_wready  = w_wready;
    assign s_axi_bvalid  = w_bvalid;
    assign s_axi_bid     = r_awid;
    assign s_axi_bresp   = w_bvalid ? r_bresp : RESP_OK;
    assign s_axi_arready = w_arready;
    assign s_axi_rvalid  = w_rvalid;
    assign s_axi_rlast   = w_rlast;
    assign s_axi_rid     = r_arid;
    assign s_axi_rresp   = (w_rvalid && r_rerr) ? RESP_ERR : RESP_OK;
    assign s_axi_rdata   = (RD_MODE == 1) ? w_addr_ext : RD_CONST;
    assign wr_cnt        = r_wr_cnt;
    assign rd_cnt        = r_rd_cnt;

endmodule
